// File: rtl/button_ctl_pkg.sv
// Shared constants and types for the pushbutton front end: debounce FSM states,
// default timing at 65 MHz, and a helper for sizing the shared counter width.
package button_ctl_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 650000;    // 10 ms
  localparam int DEF_REPEAT_DELAY    = 19500000;  // 300 ms
  localparam int DEF_REPEAT_CYCLES   = 1083333;   // ~60 Hz

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM and a one-cycle
// press strobe registered on entry to ST_HELD.
//
// state           | meaning
// ST_RELEASED     | stable released, level 0
// ST_PRESS_WAIT   | input went high, counting stable 1s, level 0
// ST_HELD         | accepted press, level 1
// ST_RELEASE_WAIT | input went low, counting stable 0s, level 1
module button_debounce
  import button_ctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 21
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic held_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press_q, press_d;
  logic             in_s;

  assign in_s    = sync_q[1];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      ST_RELEASED: begin
        if (in_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!in_s) begin
          state_d = ST_RELEASED;
        end else if (cnt_q >= LAST) begin
          state_d = ST_HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        if (!in_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        // a bounce back high resumes the hold without a new strobe
        if (in_s) begin
          state_d = ST_HELD;
        end else if (cnt_q >= LAST) begin
          state_d = ST_RELEASED;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_RELEASED;
    endcase
  end

  assign level_o = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
  assign held_o  = (state_q == ST_HELD);
  assign press_o = press_q;

endmodule

// File: rtl/button_ctl.sv
// Three debounced pushbuttons with left/right step strobes and a fire strobe.
// Define BUTTON_AUTOREPEAT_EN to add auto-repeat steps on held left/right.
module button_ctl
  import button_ctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  input  logic btn_fire_raw,
  output logic button_left,
  output logic button_right,
  output logic step_left,
  output logic step_right,
  output logic fire_pulse
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_CYCLES)) + 1;

  // index 0 = left, 1 = right
  logic [1:0] lvl, held, press, rpt;
  logic [1:0] step_q, step_d;
  logic       lvl_f, held_f, press_f;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_left (
    .clk_i(clk), .rst_i(rst), .raw_i(btn_left_raw),
    .level_o(lvl[0]), .held_o(held[0]), .press_o(press[0])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_right (
    .clk_i(clk), .rst_i(rst), .raw_i(btn_right_raw),
    .level_o(lvl[1]), .held_o(held[1]), .press_o(press[1])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_fire (
    .clk_i(clk), .rst_i(rst), .raw_i(btn_fire_raw),
    .level_o(lvl_f), .held_o(held_f), .press_o(press_f)
  );

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_CYCLES);

  logic [CNT_W-1:0] rcnt_q [2];
  logic [CNT_W-1:0] rcnt_d [2];
  logic [1:0]       rfirst_q, rfirst_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q[0] <= '0;
      rcnt_q[1] <= '0;
      rfirst_q  <= 2'b11;
    end else begin
      rcnt_q[0] <= rcnt_d[0];
      rcnt_q[1] <= rcnt_d[1];
      rfirst_q  <= rfirst_d;
    end
  end

  // counter only advances in ST_HELD, so a release bounce pauses it
  always_comb begin
    rcnt_d   = rcnt_q;
    rfirst_d = rfirst_q;
    rpt      = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (!lvl[i]) begin
        rcnt_d[i]   = '0;
        rfirst_d[i] = 1'b1;
      end else if (press[i]) begin
        rcnt_d[i]   = CNT_W'(1);
        rfirst_d[i] = 1'b1;
      end else if (held[i]) begin
        if (rcnt_q[i] == (rfirst_q[i] ? RPT_FIRST : RPT_NEXT)) begin
          rpt[i]      = 1'b1;
          rcnt_d[i]   = CNT_W'(1);
          rfirst_d[i] = 1'b0;
        end else if (rcnt_q[i] != '1) begin
          rcnt_d[i] = rcnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{lvl_f, held_f};
`else
  assign rpt = 2'b00;

  logic unused_ok;
  assign unused_ok = ^{lvl_f, held_f, held};
`endif

  assign step_d = press | rpt;

  always_ff @(posedge clk) begin
    if (rst) step_q <= 2'b00;
    else     step_q <= step_d;
  end

  assign button_left  = lvl[0];
  assign button_right = lvl[1];
  assign step_left    = step_q[0] & ~(lvl[0] & lvl[1]);
  assign step_right   = step_q[1] & ~(lvl[0] & lvl[1]);
  assign fire_pulse   = press_f;

endmodule
